dm9000a_init_seq: RTL and testbench

DM9000A_INIT_SEQ -- requirements
Module: dm9000a_init_seq

---
 rtl/dm9000a_init_seq_pkg.sv | 73 +++++++
 rtl/dm9000a_init_seq_delay_cnt.sv | 25 ++
 rtl/dm9000a_init_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dm9000a_init_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm9000a_init_seq_pkg.sv
// rtl/dm9000a_init_seq_pkg.sv - DM9000A register map, ID constants, FSM/error enums and config table
package ProtocolInfo;

    // DM9000A register indices touched by the init sequence
    localparam logic [7:0] REG_NCR  = 8'h00;
    localparam logic [7:0] REG_NSR  = 8'h01;
    localparam logic [7:0] REG_RCR  = 8'h05;
    localparam logic [7:0] REG_GPR  = 8'h1F;
    localparam logic [7:0] REG_VIDL = 8'h28;
    localparam logic [7:0] REG_VIDH = 8'h29;
    localparam logic [7:0] REG_PIDL = 8'h2A;
    localparam logic [7:0] REG_PIDH = 8'h2B;
    localparam logic [7:0] REG_ISR  = 8'hFE;
    localparam logic [7:0] REG_IMR  = 8'hFF;

    // Identity the chip must report before it is configured
    localparam logic [15:0] VENDOR_ID_EXP  = 16'h0A46;
    localparam logic [15:0] PRODUCT_ID_EXP = 16'h9000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HW_RST,
        ST_HW_WAIT,
        ST_ID_RD,
        ST_ID_CHK,
        ST_CFG_WR,
        ST_CFG_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ID      = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    // Which parameterised delay follows a config write
    typedef enum logic [1:0] {
        WAIT_NONE,
        WAIT_PHY,
        WAIT_RST
    } wait_sel_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        wait_sel_t  wait_sel;
    } cfg_entry_t;

    localparam int CFG_LEN = 6;

    // PHY power-up, software reset, clear status, clear ISR, enable RX, enable IRQs
    localparam cfg_entry_t CFG_TABLE [CFG_LEN] = '{
        '{addr: REG_GPR, data: 8'h00, wait_sel: WAIT_PHY},
        '{addr: REG_NCR, data: 8'h01, wait_sel: WAIT_RST},
        '{addr: REG_NSR, data: 8'h2C, wait_sel: WAIT_NONE},
        '{addr: REG_ISR, data: 8'h3F, wait_sel: WAIT_NONE},
        '{addr: REG_RCR, data: 8'h39, wait_sel: WAIT_NONE},
        '{addr: REG_IMR, data: 8'h81, wait_sel: WAIT_NONE}
    };

    // Out-of-range indices (after the last entry) read as an all-zero entry
    function automatic cfg_entry_t cfg_lookup(input logic [2:0] idx);
        cfg_entry_t e;
        e = '{addr: 8'h00, data: 8'h00, wait_sel: WAIT_NONE};
        if (int'(idx) < CFG_LEN) begin
            e = CFG_TABLE[idx];
        end
        return e;
    endfunction

endpackage

// File: rtl/dm9000a_init_seq_delay_cnt.sv
// rtl/dm9000a_init_seq_delay_cnt.sv - loadable 32-bit down counter with zero flag
module dm9000a_delay_cnt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    output logic        o_zero
);

    logic [31:0] r_count;

    // Load wins; otherwise count down and park at zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 32'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 32'd0) begin
            r_count <= r_count - 32'd1;
        end
    end

    assign o_zero = (r_count == 32'd0);

endmodule

// File: rtl/dm9000a_init_seq.sv
// rtl/dm9000a_init_seq.sv - DM9000A hardware reset, ID check and register init sequencer
module dm9000a_init_seq
    import ProtocolInfo::*;
#(
    parameter int unsigned RST_HOLD_CYC = 1000,
    parameter int unsigned RST_WAIT_CYC = 100,
    parameter int unsigned PHY_WAIT_CYC = 2000000,
    parameter int unsigned ACK_TIMEOUT  = 1024
) (
    input  logic        clk100,
    input  logic        rst,
    input  logic        start,
    output logic        chip_rst_n,
    output logic        req,
    output logic        req_write,
    output logic [7:0]  req_addr,
    output logic [15:0] req_wdata,
    input  logic        ack,
    input  logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] vendor_id,
    output logic [15:0] product_id
);

    // A wait of N cycles loads N-1 and leaves the state on the zero flag
    localparam logic [31:0] C_HOLD_LD = (RST_HOLD_CYC > 0) ? 32'(RST_HOLD_CYC - 1) : 32'd0;
    localparam logic [31:0] C_RSTW_LD = (RST_WAIT_CYC > 0) ? 32'(RST_WAIT_CYC - 1) : 32'd0;
    localparam logic [31:0] C_TO_LD   = (ACK_TIMEOUT  > 0) ? 32'(ACK_TIMEOUT  - 1) : 32'd0;

    function automatic logic [31:0] wait_len(input wait_sel_t sel);
        case (sel)
            WAIT_PHY: return 32'(PHY_WAIT_CYC);
            WAIT_RST: return 32'(RST_WAIT_CYC);
            default:  return 32'd0;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic        r_req;
    logic        r_write;
    logic [7:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_vendor;
    logic [15:0] r_product;
    err_code_t   r_err;

    logic        w_cnt_load;
    logic [31:0] w_cnt_val;
    logic        w_cnt_zero;
    logic        w_launch;
    logic        w_ack_ok;
    logic        w_timeout;
    logic        w_id_fail;
    logic        w_clear;
    logic        w_idx_clr;
    logic        w_l_write;
    logic [7:0]  w_l_addr;
    logic [15:0] w_l_wdata;
    cfg_entry_t  w_cur_cfg;
    logic [31:0] w_cur_wait;
    logic        w_unused_rdata_hi;

    assign w_cur_cfg         = cfg_lookup(r_idx);
    assign w_cur_wait        = wait_len(w_cur_cfg.wait_sel);
    assign w_unused_rdata_hi = ^rdata[15:8];

    // One counter serves every wait state and the per-access ack timeout
    dm9000a_delay_cnt u_delay_cnt (
        .i_clk      (clk100),
        .i_rst      (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the strobes that steer the access and capture registers
    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_val  = C_TO_LD;
        w_launch   = 1'b0;
        w_ack_ok   = 1'b0;
        w_timeout  = 1'b0;
        w_id_fail  = 1'b0;
        w_clear    = 1'b0;
        w_idx_clr  = 1'b0;
        w_l_write  = 1'b0;
        w_l_addr   = 8'h00;
        w_l_wdata  = 16'h0000;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_clear = 1'b1;
                    if (RST_HOLD_CYC != 0) begin
                        w_next     = ST_HW_RST;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = C_HOLD_LD;
                    end else if (RST_WAIT_CYC != 0) begin
                        w_next     = ST_HW_WAIT;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = C_RSTW_LD;
                    end else begin
                        w_next = ST_ID_RD;
                    end
                end
            end
            ST_HW_RST: begin
                if (w_cnt_zero) begin
                    if (RST_WAIT_CYC != 0) begin
                        w_next     = ST_HW_WAIT;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = C_RSTW_LD;
                    end else begin
                        w_next = ST_ID_RD;
                    end
                end
            end
            ST_HW_WAIT: begin
                if (w_cnt_zero) begin
                    w_next = ST_ID_RD;
                end
            end
            ST_ID_RD: begin
                w_l_addr = REG_VIDL + {5'd0, r_idx};
                if (!r_req) begin
                    w_launch   = 1'b1;
                    w_cnt_load = 1'b1;
                end else if (ack) begin
                    w_ack_ok = 1'b1;
                    if (r_idx == 3'd3) begin
                        w_next = ST_ID_CHK;
                    end
                end else if (w_cnt_zero) begin
                    w_timeout = 1'b1;
                    w_next    = ST_ERROR;
                end
            end
            ST_ID_CHK: begin
                w_idx_clr = 1'b1;
                if (r_vendor == VENDOR_ID_EXP && r_product == PRODUCT_ID_EXP) begin
                    w_next = ST_CFG_WR;
                end else begin
                    w_id_fail = 1'b1;
                    w_next    = ST_ERROR;
                end
            end
            ST_CFG_WR: begin
                w_l_write = 1'b1;
                w_l_addr  = w_cur_cfg.addr;
                w_l_wdata = {8'h00, w_cur_cfg.data};
                if (!r_req) begin
                    w_launch   = 1'b1;
                    w_cnt_load = 1'b1;
                end else if (ack) begin
                    w_ack_ok = 1'b1;
                    if (w_cur_wait != 32'd0) begin
                        w_next     = ST_CFG_WAIT;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = w_cur_wait - 32'd1;
                    end else if (r_idx == 3'(CFG_LEN - 1)) begin
                        w_next = ST_DONE;
                    end
                end else if (w_cnt_zero) begin
                    w_timeout = 1'b1;
                    w_next    = ST_ERROR;
                end
            end
            ST_CFG_WAIT: begin
                // The wait itself is the low gap, so the next write launches on exit
                w_l_write = 1'b1;
                w_l_addr  = w_cur_cfg.addr;
                w_l_wdata = {8'h00, w_cur_cfg.data};
                if (w_cnt_zero) begin
                    if (r_idx == 3'(CFG_LEN)) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_CFG_WR;
                        w_launch   = 1'b1;
                        w_cnt_load = 1'b1;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        chip_rst_n = 1'b1;
        case (r_state)
            ST_IDLE:   busy = 1'b0;
            ST_DONE:   begin busy = 1'b0; done  = 1'b1; end
            ST_ERROR:  begin busy = 1'b0; error = 1'b1; end
            ST_HW_RST: chip_rst_n = 1'b0;
            default:   ;
        endcase
    end

    // Access request, table index, ID capture and error code registers
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 16'h0000;
            r_idx     <= 3'd0;
            r_vendor  <= 16'h0000;
            r_product <= 16'h0000;
            r_err     <= ERR_NONE;
        end else begin
            if (w_launch) begin
                r_req   <= 1'b1;
                r_write <= w_l_write;
                r_addr  <= w_l_addr;
                r_wdata <= w_l_wdata;
            end else if (w_ack_ok || w_timeout) begin
                r_req <= 1'b0;
            end

            if (w_clear || w_idx_clr) begin
                r_idx <= 3'd0;
            end else if (w_ack_ok) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_clear) begin
                r_vendor  <= 16'h0000;
                r_product <= 16'h0000;
            end else if (w_ack_ok && r_state == ST_ID_RD) begin
                case (r_idx[1:0])
                    2'd0: r_vendor[7:0]   <= rdata[7:0];
                    2'd1: r_vendor[15:8]  <= rdata[7:0];
                    2'd2: r_product[7:0]  <= rdata[7:0];
                    default: r_product[15:8] <= rdata[7:0];
                endcase
            end

            if (w_clear) begin
                r_err <= ERR_NONE;
            end else if (w_id_fail) begin
                r_err <= ERR_ID;
            end else if (w_timeout) begin
                r_err <= ERR_TIMEOUT;
            end
        end
    end

    assign req        = r_req;
    assign req_write  = r_write;
    assign req_addr   = r_addr;
    assign req_wdata  = r_wdata;
    assign err_code   = r_err;
    assign vendor_id  = r_vendor;
    assign product_id = r_product;

endmodule

// File: tb/tb_dm9000a_init_seq.sv
// tb/tb_dm9000a_init_seq.sv - directed table-driven bench for dm9000a_init_seq
module tb_dm9000a_init_seq;

    logic        clk100 = 1'b0;
    logic        rst;
    logic        start;
    logic        chip_rst_n;
    logic        req;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] vendor_id;
    logic [15:0] product_id;

    always #5 clk100 = ~clk100;

    dm9000a_init_seq #(
        .RST_HOLD_CYC (4),
        .RST_WAIT_CYC (3),
        .PHY_WAIT_CYC (5),
        .ACK_TIMEOUT  (8)
    ) dut (
        .clk100     (clk100),
        .rst        (rst),
        .start      (start),
        .chip_rst_n (chip_rst_n),
        .req        (req),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .vendor_id  (vendor_id),
        .product_id (product_id)
    );

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    typedef struct {
        logic [7:0]  rbyte;
        logic        write;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } vec_t;

    // Responder configuration (written by the main sequence only)
    int         ack_dly     = 2;
    bit         ack_low     = 1'b0;
    bit         drop_en     = 1'b0;
    logic [7:0] drop_addr   = 8'h00;
    int         spur_at_cyc = -1;
    logic [7:0] id_b [4];

    // Responder/monitor state (written by the responder only)
    int   cyc         = 0;
    int   rst_low_cnt = 0;
    int   tx_n        = 0;
    int   last_len    = 0;
    int   stab_err    = 0;
    txn_t tx_log [64];
    int   tx_gap [64];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus-stage model: acks ack_dly cycles after req rises, logs accepted accesses
    initial begin : responder
        logic       prev_req;
        int         age;
        int         rise_cyc;
        int         fall_cyc;
        txn_t       held;
        logic [7:0] b;
        prev_req = 1'b0;
        age      = 0;
        rise_cyc = 0;
        fall_cyc = 0;
        held     = '0;
        ack      = 1'b0;
        rdata    = 16'h0000;
        forever begin
            @(negedge clk100);
            cyc++;
            if (!chip_rst_n) rst_low_cnt++;
            if (req && !prev_req) begin
                rise_cyc = cyc;
                age      = 0;
            end else if (req) begin
                age++;
                if ({req_write, req_addr, req_wdata} != held) stab_err++;
            end
            if (!req && prev_req) begin
                last_len = cyc - rise_cyc;
                fall_cyc = cyc;
            end
            held = {req_write, req_addr, req_wdata};
            ack  = 1'b0;
            if (req && age == ack_dly && !(drop_en && req_write && req_addr == drop_addr)) ack = 1'b1;
            if (ack_low && !req) ack = 1'b1;
            if (cyc == spur_at_cyc) ack = 1'b1;
            b = 8'h00;
            if (req_addr >= 8'h28 && req_addr <= 8'h2B) b = id_b[req_addr - 8'h28];
            rdata = {8'hA5, b};
            if (req && ack) begin
                tx_log[tx_n] = {req_write, req_addr, req_wdata};
                tx_gap[tx_n] = rise_cyc - fall_cyc;
                tx_n++;
            end
            prev_req = req;
        end
    end

    task automatic do_start();
        @(negedge clk100);
        start = 1'b1;
        @(negedge clk100);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk100);
            k++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_chip_rst_n"}, {31'd0, chip_rst_n}, 32'd1);
        check({tag, "_req"},        {31'd0, req},        32'd0);
        check({tag, "_req_write"},  {31'd0, req_write},  32'd0);
        check({tag, "_req_addr"},   {24'd0, req_addr},   32'd0);
        check({tag, "_req_wdata"},  {16'd0, req_wdata},  32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_error"},      {31'd0, error},      32'd0);
        check({tag, "_err_code"},   {30'd0, err_code},   32'd0);
        check({tag, "_vendor_id"},  {16'd0, vendor_id},  32'd0);
        check({tag, "_product_id"}, {16'd0, product_id}, 32'd0);
    endtask

    initial begin : main
        vec_t vt [10];
        int   base;
        int   rl0;
        int   k;

        vt[0] = '{8'h46, 1'b0, 8'h28, 16'h0000};
        vt[1] = '{8'h0A, 1'b0, 8'h29, 16'h0000};
        vt[2] = '{8'h00, 1'b0, 8'h2A, 16'h0000};
        vt[3] = '{8'h90, 1'b0, 8'h2B, 16'h0000};
        vt[4] = '{8'h00, 1'b1, 8'h1F, 16'h0000};
        vt[5] = '{8'h00, 1'b1, 8'h00, 16'h0001};
        vt[6] = '{8'h00, 1'b1, 8'h01, 16'h002C};
        vt[7] = '{8'h00, 1'b1, 8'hFE, 16'h003F};
        vt[8] = '{8'h00, 1'b1, 8'h05, 16'h0039};
        vt[9] = '{8'h00, 1'b1, 8'hFF, 16'h0081};
        for (int i = 0; i < 4; i++) id_b[i] = vt[i].rbyte;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk100);
        check_reset_values("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk100);

        // Nominal sequence
        base = tx_n;
        rl0  = rst_low_cnt;
        do_start();
        check("nom_busy", {31'd0, busy}, 32'd1);
        wait_idle(300, "nom_finish");
        check("nom_tx_count", 32'(tx_n - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("nom_txn%0d", i), {7'd0, tx_log[base + i]},
                  {7'd0, vt[i].write, vt[i].addr, vt[i].wdata});
        end
        check("nom_rst_low", 32'(rst_low_cnt - rl0), 32'd4);
        check("nom_gap_phy", 32'(tx_gap[base + 5]), 32'd5);
        check("nom_gap_ncr", 32'(tx_gap[base + 6]), 32'd3);
        check("nom_gap_plain", 32'(tx_gap[base + 7]), 32'd1);
        check("nom_done", {31'd0, done}, 32'd1);
        check("nom_error", {31'd0, error}, 32'd0);
        check("nom_vendor", {16'd0, vendor_id}, 32'h0A46);
        check("nom_product", {16'd0, product_id}, 32'h9000);
        check("nom_stable", 32'(stab_err), 32'd0);

        // ID mismatch, started from DONE
        id_b[3] = 8'h91;
        base = tx_n;
        do_start();
        check("mis_done_cleared", {31'd0, done}, 32'd0);
        check("mis_restart_rst", {31'd0, chip_rst_n}, 32'd0);
        check("mis_vendor_cleared", {16'd0, vendor_id}, 32'd0);
        wait_idle(300, "mis_finish");
        check("mis_tx_count", 32'(tx_n - base), 32'd4);
        check("mis_error", {31'd0, error}, 32'd1);
        check("mis_done", {31'd0, done}, 32'd0);
        check("mis_err_code", {30'd0, err_code}, 32'd1);
        check("mis_product", {16'd0, product_id}, 32'h9100);
        check("mis_vendor", {16'd0, vendor_id}, 32'h0A46);

        // Ack timeout on the 0x05 write, started from ERROR
        id_b[3]   = 8'h90;
        drop_en   = 1'b1;
        drop_addr = 8'h05;
        base = tx_n;
        do_start();
        check("to_error_cleared", {31'd0, error}, 32'd0);
        check("to_err_code_cleared", {30'd0, err_code}, 32'd0);
        check("to_product_cleared", {16'd0, product_id}, 32'd0);
        wait_idle(300, "to_finish");
        check("to_error", {31'd0, error}, 32'd1);
        check("to_err_code", {30'd0, err_code}, 32'd2);
        check("to_req_len", 32'(last_len), 32'd8);
        check("to_req_low", {31'd0, req}, 32'd0);
        check("to_tx_count", 32'(tx_n - base), 32'd8);
        check("to_last_addr", {24'd0, tx_log[tx_n - 1].addr}, 32'hFE);
        drop_en = 1'b0;

        // Reset during the PHY power-up wait, then a spurious ack
        base = tx_n;
        do_start();
        k = 0;
        while (tx_n < base + 5 && k < 200) begin
            @(negedge clk100);
            k++;
        end
        check("rmw_reached_phy_wr", 32'(tx_n - base), 32'd5);
        @(negedge clk100);
        @(negedge clk100);
        check("rmw_in_wait_busy", {31'd0, busy}, 32'd1);
        check("rmw_in_wait_req", {31'd0, req}, 32'd0);
        rst = 1'b1;
        @(negedge clk100);
        rst = 1'b0;
        check_reset_values("rmw");
        @(posedge clk100);
        spur_at_cyc = cyc + 2;
        repeat (4) @(negedge clk100);
        check("rmw_spur_busy", {31'd0, busy}, 32'd0);
        check("rmw_spur_req", {31'd0, req}, 32'd0);
        check("rmw_spur_done", {31'd0, done}, 32'd0);
        check("rmw_spur_error", {31'd0, error}, 32'd0);
        check("rmw_spur_tx", 32'(tx_n - base), 32'd5);

        // Same-cycle acks, ack held while req is low, start while busy
        ack_dly = 0;
        ack_low = 1'b1;
        base = tx_n;
        rl0  = rst_low_cnt;
        do_start();
        repeat (12) @(negedge clk100);
        check("edge_busy_mid", {31'd0, busy}, 32'd1);
        start = 1'b1;
        @(negedge clk100);
        start = 1'b0;
        wait_idle(300, "edge_finish");
        ack_low = 1'b0;
        check("edge_done", {31'd0, done}, 32'd1);
        check("edge_tx_count", 32'(tx_n - base), 32'd10);
        check("edge_rst_low", 32'(rst_low_cnt - rl0), 32'd4);
        check("edge_req_len", 32'(last_len), 32'd1);
        check("edge_vendor", {16'd0, vendor_id}, 32'h0A46);
        check("edge_product", {16'd0, product_id}, 32'h9000);
        check("edge_last_addr", {24'd0, tx_log[tx_n - 1].addr}, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
